// File: rtl/alu_ops_pkg.sv
// Shared ALU operation indices, RV32 opcodes and decode record types.
// The ALU switches on the same OP_* constants the decoder emits.
package alu_ops_pkg;

   localparam logic [5:0] OP_ADD     = 6'd0;
   localparam logic [5:0] OP_SUB     = 6'd1;
   localparam logic [5:0] OP_SLL     = 6'd2;
   localparam logic [5:0] OP_SLT     = 6'd3;
   localparam logic [5:0] OP_SLTU    = 6'd4;
   localparam logic [5:0] OP_XOR     = 6'd5;
   localparam logic [5:0] OP_SRL     = 6'd6;
   localparam logic [5:0] OP_SRA     = 6'd7;
   localparam logic [5:0] OP_OR      = 6'd8;
   localparam logic [5:0] OP_AND     = 6'd9;
   localparam logic [5:0] OP_MUL     = 6'd10;
   localparam logic [5:0] OP_MULH    = 6'd11;
   localparam logic [5:0] OP_MULHSU  = 6'd12;
   localparam logic [5:0] OP_MULHU   = 6'd13;
   localparam logic [5:0] OP_DIV     = 6'd14;
   localparam logic [5:0] OP_DIVU    = 6'd15;
   localparam logic [5:0] OP_REM     = 6'd16;
   localparam logic [5:0] OP_REMU    = 6'd17;
   localparam logic [5:0] OP_ADDI    = 6'd18;
   localparam logic [5:0] OP_SLTI    = 6'd19;
   localparam logic [5:0] OP_SLTIU   = 6'd20;
   localparam logic [5:0] OP_XORI    = 6'd21;
   localparam logic [5:0] OP_ORI     = 6'd22;
   localparam logic [5:0] OP_ANDI    = 6'd23;
   localparam logic [5:0] OP_SLLI    = 6'd24;
   localparam logic [5:0] OP_SRLI    = 6'd25;
   localparam logic [5:0] OP_SRAI    = 6'd26;
   localparam logic [5:0] OP_LB      = 6'd27;
   localparam logic [5:0] OP_LH      = 6'd28;
   localparam logic [5:0] OP_LW      = 6'd29;
   localparam logic [5:0] OP_LBU     = 6'd30;
   localparam logic [5:0] OP_LHU     = 6'd31;
   localparam logic [5:0] OP_SB      = 6'd32;
   localparam logic [5:0] OP_SH      = 6'd33;
   localparam logic [5:0] OP_SW      = 6'd34;
   localparam logic [5:0] OP_BEQ     = 6'd35;
   localparam logic [5:0] OP_BNE     = 6'd36;
   localparam logic [5:0] OP_BLT     = 6'd37;
   localparam logic [5:0] OP_BGE     = 6'd38;
   localparam logic [5:0] OP_BLTU    = 6'd39;
   localparam logic [5:0] OP_BGEU    = 6'd40;
   localparam logic [5:0] OP_JAL     = 6'd41;
   localparam logic [5:0] OP_JALR    = 6'd42;
   localparam logic [5:0] OP_LUI     = 6'd43;
   localparam logic [5:0] OP_AUIPC   = 6'd44;
   localparam logic [5:0] OP_ILLEGAL = 6'd63;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [5:0] op;
      logic       rd_we;
      logic       multicycle;
      logic       illegal;
   } dec_t;

   typedef struct packed {
      dec_t        dec;
      logic [31:0] ir;
      logic [31:0] pc;
   } entry_t;

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational RV32IM word -> ALU operation index and side flags.
module instr_decode_comb
   import alu_ops_pkg::*;
(
   input  logic [31:0] i_ir,
   output dec_t        o_dec
);

   logic [6:0] opc_s;
   logic [2:0] f3_s;
   logic [6:0] f7_s;
   logic [5:0] op_s;
   logic       writes_s;

   assign opc_s = i_ir[6:0];
   assign f3_s  = i_ir[14:12];
   assign f7_s  = i_ir[31:25];

   // Opcode/funct3/funct7 lookup; anything not listed stays OP_ILLEGAL.
   always_comb begin
      op_s     = OP_ILLEGAL;
      writes_s = 1'b0;
      case (opc_s)
         OPC_OP: begin
            writes_s = 1'b1;
            case (f7_s)
               7'b0000000: begin
                  case (f3_s)
                     3'd0:    op_s = OP_ADD;
                     3'd1:    op_s = OP_SLL;
                     3'd2:    op_s = OP_SLT;
                     3'd3:    op_s = OP_SLTU;
                     3'd4:    op_s = OP_XOR;
                     3'd5:    op_s = OP_SRL;
                     3'd6:    op_s = OP_OR;
                     3'd7:    op_s = OP_AND;
                     default: op_s = OP_ILLEGAL;
                  endcase
               end
               7'b0100000: begin
                  if (f3_s == 3'd0)      op_s = OP_SUB;
                  else if (f3_s == 3'd5) op_s = OP_SRA;
                  else                   op_s = OP_ILLEGAL;
               end
               7'b0000001: op_s = OP_MUL + {3'd0, f3_s};
               default:    op_s = OP_ILLEGAL;
            endcase
         end
         OPC_OPIMM: begin
            writes_s = 1'b1;
            case (f3_s)
               3'd0: op_s = OP_ADDI;
               3'd2: op_s = OP_SLTI;
               3'd3: op_s = OP_SLTIU;
               3'd4: op_s = OP_XORI;
               3'd6: op_s = OP_ORI;
               3'd7: op_s = OP_ANDI;
               3'd1: begin
                  if (f7_s == 7'b0000000) op_s = OP_SLLI;
                  else                    op_s = OP_ILLEGAL;
               end
               3'd5: begin
                  if (f7_s == 7'b0000000)      op_s = OP_SRLI;
                  else if (f7_s == 7'b0100000) op_s = OP_SRAI;
                  else                         op_s = OP_ILLEGAL;
               end
               default: op_s = OP_ILLEGAL;
            endcase
         end
         OPC_LOAD: begin
            writes_s = 1'b1;
            case (f3_s)
               3'd0:    op_s = OP_LB;
               3'd1:    op_s = OP_LH;
               3'd2:    op_s = OP_LW;
               3'd4:    op_s = OP_LBU;
               3'd5:    op_s = OP_LHU;
               default: op_s = OP_ILLEGAL;
            endcase
         end
         OPC_STORE: begin
            case (f3_s)
               3'd0:    op_s = OP_SB;
               3'd1:    op_s = OP_SH;
               3'd2:    op_s = OP_SW;
               default: op_s = OP_ILLEGAL;
            endcase
         end
         OPC_BRANCH: begin
            case (f3_s)
               3'd0:    op_s = OP_BEQ;
               3'd1:    op_s = OP_BNE;
               3'd4:    op_s = OP_BLT;
               3'd5:    op_s = OP_BGE;
               3'd6:    op_s = OP_BLTU;
               3'd7:    op_s = OP_BGEU;
               default: op_s = OP_ILLEGAL;
            endcase
         end
         OPC_JAL: begin
            writes_s = 1'b1;
            op_s     = OP_JAL;
         end
         OPC_JALR: begin
            writes_s = 1'b1;
            if (f3_s == 3'd0) op_s = OP_JALR;
            else              op_s = OP_ILLEGAL;
         end
         OPC_LUI: begin
            writes_s = 1'b1;
            op_s     = OP_LUI;
         end
         OPC_AUIPC: begin
            writes_s = 1'b1;
            op_s     = OP_AUIPC;
         end
         default: begin
            op_s     = OP_ILLEGAL;
            writes_s = 1'b0;
         end
      endcase
   end

   // x0 writes are suppressed so the ALU never needs to filter them.
   assign o_dec.op         = op_s;
   assign o_dec.illegal    = (op_s == OP_ILLEGAL);
   assign o_dec.rd_we      = writes_s & (op_s != OP_ILLEGAL) & (i_ir[11:7] != 5'd0);
   assign o_dec.multicycle = (op_s >= OP_DIV) & (op_s <= OP_REMU);

endmodule

// File: rtl/instr_decoder.sv
// Decode stage: combinational decode into a main output entry backed by one skid entry,
// valid/ready on both sides, flush drops everything buffered plus the word on offer.
module instr_decoder
   import alu_ops_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_IR,
   input  logic [31:0] i_PC,
   input  logic        i_flush,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_instruction,
   output logic [31:0] o_IR,
   output logic [31:0] o_PC,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd,
   output logic        o_rd_we,
   output logic        o_is_multicycle,
   output logic        o_illegal
);

   dec_t   dec_s;
   entry_t in_entry_s;
   entry_t main_d, main_q, skid_d, skid_q;
   logic   main_valid_d, main_valid_q, skid_valid_d, skid_valid_q;
   logic   accept_s, advance_s;

   instr_decode_comb u_decode (
      .i_ir  (i_IR),
      .o_dec (dec_s)
   );

   assign in_entry_s = '{dec: dec_s, ir: i_IR, pc: i_PC};
   assign accept_s   = i_valid & ~skid_valid_q & ~i_flush;
   assign advance_s  = ~main_valid_q | i_ready;

   // Main/skid next state; skid is only ever filled while main is stalled.
   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (i_flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (advance_s) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept_s) begin
            main_d       = in_entry_s;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else begin
         if (accept_s) begin
            skid_d       = in_entry_s;
            skid_valid_d = 1'b1;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end
   end

   // Entry registers with asynchronous reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign o_ready         = ~skid_valid_q;
   assign o_valid         = main_valid_q;
   assign o_instruction   = {26'd0, main_q.dec.op};
   assign o_IR            = main_q.ir;
   assign o_PC            = main_q.pc;
   assign o_rs1           = main_q.ir[19:15];
   assign o_rs2           = main_q.ir[24:20];
   assign o_rd            = main_q.ir[11:7];
   assign o_rd_we         = main_q.dec.rd_we;
   assign o_is_multicycle = main_q.dec.multicycle;
   assign o_illegal       = main_q.dec.illegal;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench: directed scenarios then random traffic against a
// mask/match instruction table and a queue model of the two-entry buffer.
module tb_instr_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid, o_ready, i_flush, o_valid, i_ready;
   logic [31:0] i_IR, i_PC, o_instruction, o_IR, o_PC;
   logic [4:0]  o_rs1, o_rs2, o_rd;
   logic        o_rd_we, o_is_multicycle, o_illegal;

   int          n_chk = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   logic [31:0] mask_t [64];
   logic [31:0] match_t [64];
   int          op_t [64];
   int          n_t = 0;
   logic [63:0] q [$];

   always #5 clk = ~clk;

   instr_decoder dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_IR(i_IR), .i_PC(i_PC), .i_flush(i_flush), .o_valid(o_valid),
      .i_ready(i_ready), .o_instruction(o_instruction), .o_IR(o_IR), .o_PC(o_PC),
      .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_rd_we(o_rd_we),
      .o_is_multicycle(o_is_multicycle), .o_illegal(o_illegal)
   );

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] opc);
      return {f7, 10'd0, f3, 5'd0, opc};
   endfunction

   task automatic add(input logic [31:0] m, input logic [31:0] mt, input int op);
      mask_t[n_t]  = m;
      match_t[n_t] = mt;
      op_t[n_t]    = op;
      n_t++;
   endtask

   task automatic build_table();
      logic [31:0] mr, mi, mo;
      int r0 [8];
      int ii [8];
      int ld [8];
      int br [8];
      mr = enc(7'h7f, 3'd7, 7'h7f);
      mi = enc(7'h00, 3'd7, 7'h7f);
      mo = 32'h0000007f;
      r0 = '{0, 2, 3, 4, 5, 6, 8, 9};
      ii = '{18, -1, 19, 20, 21, -1, 22, 23};
      ld = '{27, 28, 29, -1, 30, 31, -1, -1};
      br = '{35, 36, -1, -1, 37, 38, 39, 40};
      for (int f = 0; f < 8; f++) begin
         add(mr, enc(7'h00, 3'(f), 7'b0110011), r0[f]);
         add(mr, enc(7'h01, 3'(f), 7'b0110011), 10 + f);
         if (ii[f] >= 0) add(mi, enc(7'h00, 3'(f), 7'b0010011), ii[f]);
         if (ld[f] >= 0) add(mi, enc(7'h00, 3'(f), 7'b0000011), ld[f]);
         if (br[f] >= 0) add(mi, enc(7'h00, 3'(f), 7'b1100011), br[f]);
         if (f < 3)      add(mi, enc(7'h00, 3'(f), 7'b0100011), 32 + f);
      end
      add(mr, enc(7'h20, 3'd0, 7'b0110011), 1);
      add(mr, enc(7'h20, 3'd5, 7'b0110011), 7);
      add(mr, enc(7'h00, 3'd1, 7'b0010011), 24);
      add(mr, enc(7'h00, 3'd5, 7'b0010011), 25);
      add(mr, enc(7'h20, 3'd5, 7'b0010011), 26);
      add(mo, 32'h0000006f, 41);
      add(mi, enc(7'h00, 3'd0, 7'b1100111), 42);
      add(mo, 32'h00000037, 43);
      add(mo, 32'h00000017, 44);
   endtask

   function automatic int ref_op(input logic [31:0] ir);
      for (int i = 0; i < n_t; i++)
         if ((ir & mask_t[i]) == match_t[i]) return op_t[i];
      return 63;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [31:0] ir, pc;
      int          op;
      logic        ill, we, mc;
      chk("o_valid", 32'(o_valid), 32'(q.size() > 0));
      chk("o_ready", 32'(o_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
         ir  = q[0][31:0];
         pc  = q[0][63:32];
         op  = ref_op(ir);
         ill = (op == 63);
         mc  = (op >= 14) && (op <= 17);
         we  = !ill && !((op >= 32) && (op <= 40)) && (ir[11:7] != 5'd0);
         chk("op", o_instruction, 32'(op));
         chk("ir", o_IR, ir);
         chk("pc", o_PC, pc);
         chk("rs1", 32'(o_rs1), 32'(ir[19:15]));
         chk("rs2", 32'(o_rs2), 32'(ir[24:20]));
         chk("rd", 32'(o_rd), 32'(ir[11:7]));
         chk("rd_we", 32'(o_rd_we), 32'(we));
         chk("multicycle", 32'(o_is_multicycle), 32'(mc));
         chk("illegal", 32'(o_illegal), 32'(ill));
      end
   endtask

   // One clock: drive inputs, update the queue model from pre-edge state, check.
   task automatic step(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                       input logic rdy, input logic fl);
      logic m_valid, m_ready;
      i_valid = v; i_IR = ir; i_PC = pc; i_ready = rdy; i_flush = fl;
      m_valid = (q.size() > 0);
      m_ready = (q.size() < 2);
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (m_valid && rdy) void'(q.pop_front());
         if (v && m_ready) q.push_back({pc, ir});
      end
      #1;
      check_outputs();
   endtask

   function automatic logic [31:0] rand_ir();
      logic [31:0] ir;
      logic [6:0]  opcs [10];
      logic [6:0]  f7s [4];
      opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
      f7s  = '{7'h00, 7'h20, 7'h01, 7'h7f};
      ir = $urandom;
      ir[6:0]   = opcs[$urandom_range(0, 9)];
      ir[31:25] = f7s[$urandom_range(0, 3)];
      return ir;
   endfunction

   initial begin
      build_table();
      rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
      i_IR = 32'd0; i_PC = 32'd0;
      #2;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_op", o_instruction, 32'd0);
      chk("rst_ir", o_IR, 32'd0);
      chk("rst_pc", o_PC, 32'd0);
      chk("rst_rd_we", 32'(o_rd_we), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 32'h002081B3, 32'h00001000, 1'b1, 1'b0);
      chk("add_op", o_instruction, 32'd0);
      chk("add_rs1", 32'(o_rs1), 32'd1);
      chk("add_rs2", 32'(o_rs2), 32'd2);
      chk("add_rd", 32'(o_rd), 32'd3);
      chk("add_we", 32'(o_rd_we), 32'd1);
      step(1'b1, 32'h027342B3, 32'h00001004, 1'b1, 1'b0);
      chk("div_op", o_instruction, 32'd14);
      chk("div_mc", 32'(o_is_multicycle), 32'd1);
      chk("div_rd", 32'(o_rd), 32'd5);
      step(1'b1, 32'h4030D093, 32'h00001008, 1'b1, 1'b0);
      chk("srai_op", o_instruction, 32'd26);
      step(1'b1, 32'hFFFFFFFF, 32'h0000100C, 1'b1, 1'b0);
      chk("ill_flag", 32'(o_illegal), 32'd1);
      chk("ill_op", o_instruction, 32'd63);
      chk("ill_we", 32'(o_rd_we), 32'd0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Backpressure: three words offered, only two fit.
      step(1'b1, 32'h00100093, 32'h00002000, 1'b0, 1'b0);
      step(1'b1, 32'h00200113, 32'h00002004, 1'b0, 1'b0);
      chk("bp_ready_low", 32'(o_ready), 32'd0);
      step(1'b1, 32'h00300193, 32'h00002008, 1'b0, 1'b0);
      chk("bp_first_held", o_IR, 32'h00100093);
      step(1'b1, 32'h00300193, 32'h00002008, 1'b1, 1'b0);
      chk("bp_second", o_IR, 32'h00200113);
      step(1'b1, 32'h00300193, 32'h00002008, 1'b1, 1'b0);
      chk("bp_third", o_IR, 32'h00300193);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Flush with both entries held and a word on offer.
      step(1'b1, 32'h00400213, 32'h00003000, 1'b0, 1'b0);
      step(1'b1, 32'h00500293, 32'h00003004, 1'b0, 1'b0);
      step(1'b1, 32'h00600313, 32'h00003008, 1'b0, 1'b1);
      chk("flush_valid", 32'(o_valid), 32'd0);
      chk("flush_ready", 32'(o_ready), 32'd1);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Asynchronous reset between clock edges.
      step(1'b1, 32'h00700393, 32'h00004000, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(o_valid), 32'd0);
      chk("arst_ready", 32'(o_ready), 32'd1);
      chk("arst_op", o_instruction, 32'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 500; n++) begin
         step($urandom_range(0, 3) != 0, rand_ir(), $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      end
      for (int n = 0; n < 3; n++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
